gelato_ibuffer: RTL and testbench
=================================

# gelato_ibuffer

Per-warp instruction buffer that receives decoded instructions from I-Decode and holds them for the issue/scoreboard stage. Instructions are kept in one in-order FIFO per warp. The block exports per-warp full and head-valid masks so fetch can throttle and issue can pick a ready warp. Per-warp flush discards queued instructions after a control-flow redirect.

## Interface
Parameters:
- WARP_NUM, 4: number of warps; warp index width is $clog2(WARP_NUM).
- THREAD_NUM, 32: thread-mask width.
- ADDR_WIDTH, 32: PC width.
- DEPTH, 4: entries per warp FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  I-Decode presents an instruction.
- in_pc  in  ADDR_WIDTH  instruction PC.
- in_warp_num  in  $clog2(WARP_NUM)  target warp.
- in_thread_mask  in  THREAD_NUM  active threads.
- in_inst  in  $bits(gelato_inst_t)  decoded instruction.
- warp_full  out  WARP_NUM  bit w = FIFO w holds DEPTH entries.
- head_valid  out  WARP_NUM  bit w = FIFO w non-empty.
- pop_valid  in  1  issue consumes the head of pop_warp.
- pop_warp  in  $clog2(WARP_NUM)  warp to pop and to view.
- out_pc, out_thread_mask, out_inst  out  as inputs  head entry of pop_warp (combinational read).
- flush_valid  in  1  discard all entries of flush_warp.
- flush_warp  in  $clog2(WARP_NUM)  warp to flush.
- err  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Each FIFO has registered rd_ptr, wr_ptr and count (width $clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Push: in_valid and !warp_full[in_warp_num]. The entry is written at wr_ptr, wr_ptr increments and count increments.
- Push to a full warp is a protocol violation. The entry is dropped and no state changes.
- Pop: pop_valid and head_valid[pop_warp]. rd_ptr increments and count decrements. Pop from an empty warp is ignored.
- Push and pop on the same warp in the same cycle: both take effect and count is unchanged. warp_full is based on registered count, so a full warp rejects a push even when it is popped that cycle.
- Flush: all pointers and count of flush_warp reset to 0. Flush has priority over a same-cycle push or pop to that warp, and both are dropped silently (not errors). Other warps are unaffected.
- out_* reflect the head of pop_warp whenever head_valid[pop_warp]. When that warp is empty, out_* are don't-care and are driven with the stale array contents.
- The storage array is not reset; only pointers, counts and err are reset.

## Timing
- Reset: warp_full=0, head_valid=0, err=0, all counts and pointers 0.
- Push at edge N: head_valid set and out_* valid from cycle N+1 (latency 1, no bypass).
- Pop at edge N: the next entry appears on out_* in cycle N+1.
- Flush at edge N: head_valid[w]=0 and warp_full[w]=0 from cycle N+1.
- Reset asserted mid-operation clears all queues at the next edge, and in-flight pushes are lost.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- GELATO_IBUF_ERR_EN defined: err sets on a push to a full warp or a pop from an empty warp. It stays set until rst.
- GELATO_IBUF_ERR_EN undefined: err is tied to 0 and no detection logic is built.

## Structure
- gelato_types holds gelato_inst_t and ibuf_entry_t (pc, thread_mask, inst).
- WARP_NUM, THREAD_NUM and ADDR_WIDTH defaults come from the shared gelato_macros definitions.
- Sub-module gelato_ibuffer_fifo implements a single-warp FIFO with push, pop, flush, full, empty and head. It is generated WARP_NUM times.
- The top level decodes the warp indices and muxes the head onto out_*.

## Test plan
- Reset, then push pc=0x100 to warp 2 → head_valid=4'b0100 next cycle, out_pc=0x100 with pop_warp=2.
- Push 4 entries to warp 1 (DEPTH=4) → warp_full[1]=1. A 5th push is dropped; with the macro, err=1. Popping 4 times returns the PCs in order.
- Simultaneous push and pop on warp 0 holding 2 entries, sustained 10 cycles → count stays 2 and order is preserved across pointer wrap.
- Warp 3 holding 3 entries, flush_warp=3 with a same-cycle push to 3 → head_valid[3]=0 next cycle and the push is discarded. Warp 0 contents are untouched.
- Pop from empty warp 1 → no state change; err=1 with the macro, 0 without it.
- Assert rst with all warps partly full → all outputs return to 0 one cycle later.

Source files
------------

// File: rtl/gelato_ibuffer_pkg.sv
// -----------------------------------------------------------------------------
// gelato_ibuffer_pkg
//
// Purpose:
//   Shared types and default sizes for the per-warp instruction buffer.
//   Provides the GPU-wide defaults (warp count, thread-mask width and PC
//   width), the decoded-instruction record passed from I-Decode to issue,
//   and the buffered entry record (pc, thread_mask, inst).
//
// Contents:
//   GELATO_WARP_NUM / GELATO_THREAD_NUM / GELATO_ADDR_WIDTH  default sizes
//   gelato_inst_t   decoded instruction fields (64 bits)
//   ibuf_entry_t    one instruction-buffer entry at the default sizes
//   INST_W          width of gelato_inst_t
//   idx_width()     index width for an N-entry selector, never below 1
// -----------------------------------------------------------------------------
package gelato_ibuffer_pkg;

    localparam int GELATO_WARP_NUM   = 4;
    localparam int GELATO_THREAD_NUM = 32;
    localparam int GELATO_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } gelato_inst_t;

    typedef struct packed {
        logic [GELATO_ADDR_WIDTH-1:0] pc;
        logic [GELATO_THREAD_NUM-1:0] thread_mask;
        gelato_inst_t                 inst;
    } ibuf_entry_t;

    localparam int INST_W = $bits(gelato_inst_t);

    // A single-warp build still needs a 1-bit warp index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : gelato_ibuffer_pkg

// File: rtl/gelato_ibuffer_fifo.sv
// -----------------------------------------------------------------------------
// gelato_ibuffer_fifo
//
// Purpose:
//   Single-warp in-order instruction FIFO. One instance exists per warp in
//   gelato_ibuffer. Entries are opaque packed words; the parent packs and
//   unpacks pc / thread_mask / inst.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (pointers and count only)
//   push_i   in   write wdata_i at the tail; ignored when full or flushing
//   pop_i    in   retire the head; ignored when empty or flushing
//   flush_i  in   discard every entry; wins over a same-cycle push/pop
//   wdata_i  in   entry to write
//   full_o   out  FIFO holds DEPTH entries (from registered count)
//   empty_o  out  FIFO holds no entries (from registered count)
//   head_o   out  combinational read of the entry at rd_ptr; stale when empty
//
// Notes:
//   DEPTH must be a power of two and at least 2 so the pointers wrap by
//   natural overflow. The storage array has no reset.
// -----------------------------------------------------------------------------
module gelato_ibuffer_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [ENTRY_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("gelato_ibuffer_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;

    // Full/empty come from the registered count only, so a full FIFO
    // refuses a push even if it is being popped in the same cycle.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_i && !full  && !flush_i;
    assign pop_ok  = pop_i  && !empty && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is written only on an accepted push and is never cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign full_o  = full;
    assign empty_o = empty;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : gelato_ibuffer_fifo

// File: rtl/gelato_ibuffer.sv
// -----------------------------------------------------------------------------
// gelato_ibuffer
//
// Purpose:
//   Per-warp instruction buffer between I-Decode and the issue/scoreboard
//   stage. Each warp owns an in-order FIFO (gelato_ibuffer_fifo). Fetch
//   throttles on warp_full, issue picks a warp from head_valid and views /
//   consumes its head through pop_warp. A per-warp flush discards queued
//   instructions after a control-flow redirect.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   in_valid         in   I-Decode presents an instruction
//   in_pc            in   instruction PC
//   in_warp_num      in   target warp of the incoming instruction
//   in_thread_mask   in   active threads
//   in_inst          in   decoded instruction
//   warp_full        out  bit w: FIFO w holds DEPTH entries
//   head_valid       out  bit w: FIFO w is non-empty
//   pop_valid        in   issue consumes the head of pop_warp
//   pop_warp         in   warp to pop and to view on out_*
//   out_pc           out  head PC of pop_warp (combinational)
//   out_thread_mask  out  head thread mask of pop_warp (combinational)
//   out_inst         out  head instruction of pop_warp (combinational)
//   flush_valid      in   discard all entries of flush_warp
//   flush_warp       in   warp to flush
//   err              out  sticky protocol-error flag
//
// Configuration:
//   GELATO_IBUF_ERR_EN  when defined, err latches on a push to a full warp
//                       or a pop from an empty warp and holds until rst.
//                       When undefined, err is tied low and no detection
//                       logic exists.
//
// Notes:
//   A flush silently drops a same-cycle push or pop to the flushed warp;
//   neither counts as a protocol error. out_* carry stale storage contents
//   when the viewed warp is empty.
// -----------------------------------------------------------------------------
module gelato_ibuffer
    import gelato_ibuffer_pkg::*;
#(
    parameter int WARP_NUM   = GELATO_WARP_NUM,
    parameter int THREAD_NUM = GELATO_THREAD_NUM,
    parameter int ADDR_WIDTH = GELATO_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              in_valid,
    input  logic [ADDR_WIDTH-1:0]             in_pc,
    input  logic [idx_width(WARP_NUM)-1:0]    in_warp_num,
    input  logic [THREAD_NUM-1:0]             in_thread_mask,
    input  gelato_inst_t                      in_inst,

    output logic [WARP_NUM-1:0]               warp_full,
    output logic [WARP_NUM-1:0]               head_valid,

    input  logic                              pop_valid,
    input  logic [idx_width(WARP_NUM)-1:0]    pop_warp,
    output logic [ADDR_WIDTH-1:0]             out_pc,
    output logic [THREAD_NUM-1:0]             out_thread_mask,
    output gelato_inst_t                      out_inst,

    input  logic                              flush_valid,
    input  logic [idx_width(WARP_NUM)-1:0]    flush_warp,

    output logic                              err
);

    localparam int WIDX_W  = idx_width(WARP_NUM);
    localparam int ENTRY_W = ADDR_WIDTH + THREAD_NUM + INST_W;

    logic [WARP_NUM-1:0] push_sel;
    logic [WARP_NUM-1:0] pop_sel;
    logic [WARP_NUM-1:0] flush_sel;
    logic [WARP_NUM-1:0] fifo_empty;

    logic [ENTRY_W-1:0]  wdata;
    logic [ENTRY_W-1:0]  head_data [WARP_NUM];
    logic [ENTRY_W-1:0]  head_mux;

    // One-hot decode of the three warp selectors. Indices beyond WARP_NUM
    // (non power-of-two warp counts) select nothing.
    always_comb begin
        push_sel  = '0;
        pop_sel   = '0;
        flush_sel = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            push_sel[w]  = in_valid    && (in_warp_num == WIDX_W'(w));
            pop_sel[w]   = pop_valid   && (pop_warp    == WIDX_W'(w));
            flush_sel[w] = flush_valid && (flush_warp  == WIDX_W'(w));
        end
    end

    assign wdata = {in_pc, in_thread_mask, in_inst};

    for (genvar g = 0; g < WARP_NUM; g++) begin : g_warp
        gelato_ibuffer_fifo #(
            .DEPTH   (DEPTH),
            .ENTRY_W (ENTRY_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_sel[g]),
            .pop_i   (pop_sel[g]),
            .flush_i (flush_sel[g]),
            .wdata_i (wdata),
            .full_o  (warp_full[g]),
            .empty_o (fifo_empty[g]),
            .head_o  (head_data[g])
        );
    end

    assign head_valid = ~fifo_empty;

    // Head view of pop_warp. Out-of-range indices fall back to warp 0.
    always_comb begin
        head_mux = head_data[0];
        for (int w = 1; w < WARP_NUM; w++) begin
            if (pop_warp == WIDX_W'(w)) begin
                head_mux = head_data[w];
            end
        end
    end

    assign {out_pc, out_thread_mask, out_inst} = head_mux;

`ifdef GELATO_IBUF_ERR_EN
    logic err_q;
    logic err_d;
    logic push_err;
    logic pop_err;

    // Violations on a warp being flushed this cycle are swallowed by the
    // flush and do not raise err.
    assign push_err = |(push_sel & warp_full  & ~flush_sel);
    assign pop_err  = |(pop_sel  & fifo_empty & ~flush_sel);
    assign err_d    = err_q | push_err | pop_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule : gelato_ibuffer

// File: tb/tb_gelato_ibuffer.sv
module tb_gelato_ibuffer;
    import gelato_ibuffer_pkg::*;

    localparam int WN    = 4;
    localparam int TN    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
`ifdef GELATO_IBUF_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [AW-1:0] in_pc;
    logic [1:0]    in_warp_num;
    logic [TN-1:0] in_thread_mask;
    gelato_inst_t  in_inst;
    logic [WN-1:0] warp_full;
    logic [WN-1:0] head_valid;
    logic          pop_valid;
    logic [1:0]    pop_warp;
    logic [AW-1:0] out_pc;
    logic [TN-1:0] out_thread_mask;
    gelato_inst_t  out_inst;
    logic          flush_valid;
    logic [1:0]    flush_warp;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] sb_q [$];
    logic [AW-1:0] mon_pc;
    logic          exp_err;

    gelato_ibuffer #(
        .WARP_NUM   (WN),
        .THREAD_NUM (TN),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_warp_num     (in_warp_num),
        .in_thread_mask  (in_thread_mask),
        .in_inst         (in_inst),
        .warp_full       (warp_full),
        .head_valid      (head_valid),
        .pop_valid       (pop_valid),
        .pop_warp        (pop_warp),
        .out_pc          (out_pc),
        .out_thread_mask (out_thread_mask),
        .out_inst        (out_inst),
        .flush_valid     (flush_valid),
        .flush_warp      (flush_warp),
        .err             (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Mask and instruction payloads are derived from the PC so every entry
    // is distinguishable in all three fields.
    function automatic logic [TN-1:0] mk(input logic [AW-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic gelato_inst_t ins(input logic [AW-1:0] pc);
        logic [63:0] raw;
        raw = {~pc, pc};
        return gelato_inst_t'(raw);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every presented pop is matched against the queue.
    always @(negedge clk) begin
        if (!rst && pop_valid && head_valid[pop_warp]) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_pop: got pc %0h on warp %0d, required no pop", out_pc, pop_warp);
            end else begin
                mon_pc = sb_q.pop_front();
                chk("pop_pc",   64'(out_pc),          64'(mon_pc));
                chk("pop_mask", 64'(out_thread_mask), 64'(mk(mon_pc)));
                chk("pop_inst", 64'(out_inst),        64'(ins(mon_pc)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        pop_valid   = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic drive_push(input int w, input logic [AW-1:0] pc);
        in_valid       = 1'b1;
        in_warp_num    = 2'(w);
        in_pc          = pc;
        in_thread_mask = mk(pc);
        in_inst        = ins(pc);
    endtask

    task automatic drive_pop(input int w, input logic [AW-1:0] pc_exp);
        pop_valid = 1'b1;
        pop_warp  = 2'(w);
        sb_q.push_back(pc_exp);
    endtask

    initial begin
        rst            = 1'b1;
        idle();
        in_pc          = '0;
        in_warp_num    = '0;
        in_thread_mask = '0;
        in_inst        = '0;
        pop_warp       = '0;
        flush_warp     = '0;
        exp_err        = 1'b0;
        tick();
        tick();
        chk("reset_full", 64'(warp_full),  64'(4'b0000));
        chk("reset_head", 64'(head_valid), 64'(4'b0000));
        chk("reset_err",  64'(err),        64'(1'b0));
        rst = 1'b0;

        // Single push to warp 2, visible next cycle.
        drive_push(2, 32'h100);
        pop_warp = 2'd2;
        tick();
        idle();
        chk("t1_head_valid", 64'(head_valid), 64'(4'b0100));
        chk("t1_out_pc",     64'(out_pc),     64'(32'h100));
        drive_pop(2, 32'h100);
        tick();
        idle();
        chk("t1_drained", 64'(head_valid), 64'(4'b0000));

        // Fill warp 1, overflow push, drain in order.
        for (int i = 0; i < 4; i++) begin
            drive_push(1, 32'h200 + 32'(4 * i));
            tick();
        end
        idle();
        chk("t2_full",  64'(warp_full),  64'(4'b0010));
        chk("t2_head",  64'(head_valid), 64'(4'b0010));
        drive_push(1, 32'h210);
        tick();
        idle();
        exp_err = ERR_EN;
        chk("t2_overflow_err",  64'(err),       64'(exp_err));
        chk("t2_overflow_full", 64'(warp_full), 64'(4'b0010));
        for (int i = 0; i < 4; i++) begin
            drive_pop(1, 32'h200 + 32'(4 * i));
            tick();
        end
        idle();
        chk("t2_empty_head", 64'(head_valid), 64'(4'b0000));
        chk("t2_empty_full", 64'(warp_full),  64'(4'b0000));

        // Warp 0 at two entries, sustained push+pop across pointer wrap.
        drive_push(0, 32'h300);
        tick();
        drive_push(0, 32'h304);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            drive_push(0, 32'h308 + 32'(4 * i));
            drive_pop(0, 32'h300 + 32'(4 * i));
            tick();
            chk("t3_full0", 64'(warp_full[0]),  64'(1'b0));
            chk("t3_head0", 64'(head_valid[0]), 64'(1'b1));
        end
        idle();

        // Warp 3 with three entries, flushed with a same-cycle push.
        for (int i = 0; i < 3; i++) begin
            drive_push(3, 32'h400 + 32'(4 * i));
            tick();
        end
        idle();
        chk("t4_pre_head", 64'(head_valid), 64'(4'b1001));
        drive_push(3, 32'h40C);
        flush_valid = 1'b1;
        flush_warp  = 2'd3;
        tick();
        idle();
        chk("t4_flush_head", 64'(head_valid), 64'(4'b0001));
        chk("t4_flush_full", 64'(warp_full),  64'(4'b0000));
        chk("t4_flush_err",  64'(err),        64'(exp_err));
        // Warp 0 keeps exactly its two surviving entries.
        drive_pop(0, 32'h328);
        tick();
        drive_pop(0, 32'h32C);
        tick();
        idle();
        chk("t4_w0_drained", 64'(head_valid), 64'(4'b0000));
        // Warp 3 restarts cleanly after the flush.
        drive_push(3, 32'h500);
        tick();
        idle();
        drive_pop(3, 32'h500);
        tick();
        idle();
        chk("t4_w3_drained", 64'(head_valid), 64'(4'b0000));

        // Pop from an empty warp after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        chk("t5_err_cleared", 64'(err), 64'(1'b0));
        pop_valid = 1'b1;
        pop_warp  = 2'd1;
        tick();
        idle();
        exp_err = ERR_EN;
        chk("t5_underflow_err",  64'(err),        64'(exp_err));
        chk("t5_underflow_head", 64'(head_valid), 64'(4'b0000));
        chk("t5_underflow_full", 64'(warp_full),  64'(4'b0000));

        // Partly fill every warp, then reset with an in-flight push.
        for (int w = 0; w < WN; w++) begin
            for (int i = 0; i <= w; i++) begin
                drive_push(w, 32'h700 + 32'(16 * w) + 32'(4 * i));
                tick();
            end
        end
        idle();
        chk("t6_fill_head", 64'(head_valid), 64'(4'b1111));
        chk("t6_fill_full", 64'(warp_full),  64'(4'b1000));
        rst = 1'b1;
        drive_push(0, 32'h7F0);
        tick();
        rst = 1'b0;
        idle();
        chk("t6_rst_head", 64'(head_valid), 64'(4'b0000));
        chk("t6_rst_full", 64'(warp_full),  64'(4'b0000));
        chk("t6_rst_err",  64'(err),        64'(1'b0));
        tick();
        chk("t6_post_head", 64'(head_valid), 64'(4'b0000));

        chk("sb_drain", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gelato_ibuffer
